// File: rtl/adc_frame_collector.sv
// Collects per-channel ADC words into a NUM_CH-slot frame and double-buffers it for the host.
// Latency: COMMIT one cycle after the last word; frame_ready the cycle after that; host reads one cycle.
// No backpressure: late or extra words are flagged in err_status, and an unread frame is overwritten (overrun).
module adc_frame_collector #(
  parameter int NUM_CH      = 6,
  parameter int SYNC_PERIOD = 4096
) (
  input  logic        SCLK,
  input  logic        rst_l,
  input  logic        enable,
  input  logic        operation_mode,
  input  logic        rd_en,
  input  logic [2:0]  channel,
  input  logic [15:0] captured_data,
  output logic        sync,
  output logic        frame_ready,
  input  logic        frame_ack,
  output logic [7:0]  frame_seq,
  input  logic        rd_req,
  input  logic [2:0]  rd_ch,
  output logic [15:0] rd_data,
  output logic        rd_ack,
  output logic [2:0]  err_status,
  input  logic        clear_err
);

  localparam logic [2:0]        CH_LIM    = 3'(NUM_CH);
  localparam logic [15:0]       PER_LOAD  = 16'(SYNC_PERIOD - 1);
  localparam logic [NUM_CH-1:0] MASK_FULL = '1;

  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_COLLECT, ST_COMMIT, ST_WAIT} state_t;

  state_t            state, state_nxt;
  logic [15:0]       pcnt;
  logic [NUM_CH-1:0] mask, mask_nxt;
  logic [15:0]       col_bank [NUM_CH];
  logic [15:0]       out_bank [NUM_CH];
  logic              col_we, commit;
  logic [2:0]        err_set;
  logic              run, ch_ok, rd_ch_ok, pcnt_zero;

  assign run       = enable & operation_mode;
  assign ch_ok     = channel < CH_LIM;
  assign rd_ch_ok  = rd_ch < CH_LIM;
  assign pcnt_zero = (pcnt == 16'd0);

  // State register
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, collect-mask update, strobes and error events
  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    col_we    = 1'b0;
    commit    = 1'b0;
    err_set   = '0;
    sync      = 1'b0;
    case (state)
      ST_IDLE: if (run) state_nxt = ST_ARM;
      ST_ARM: begin
        sync      = 1'b1;
        mask_nxt  = '0;
        state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (rd_en) begin
          if (ch_ok) begin
            col_we            = 1'b1;
            err_set[1]        = mask[channel];
            mask_nxt[channel] = 1'b1;
          end else begin
            err_set[1] = 1'b1;
          end
        end
        // A frame completing on the last counted cycle still commits
        if (mask_nxt == MASK_FULL) state_nxt = ST_COMMIT;
        else if (pcnt_zero) begin
          err_set[0] = 1'b1;
          state_nxt  = ST_ARM;
        end
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        err_set[2] = frame_ready & ~frame_ack;
        state_nxt  = pcnt_zero ? ST_ARM : ST_WAIT;
      end
      ST_WAIT: begin
        err_set[1] = rd_en;
        if (pcnt_zero) state_nxt = ST_ARM;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Losing run drops everything in flight silently
    if (!run) begin
      state_nxt = ST_IDLE;
      commit    = 1'b0;
      col_we    = 1'b0;
      err_set   = '0;
    end
  end

  // Period counter: cleared in IDLE, loaded on sync, counts down to 0 otherwise
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) pcnt <= '0;
    else begin
      case (state)
        ST_IDLE: pcnt <= '0;
        ST_ARM:  pcnt <= PER_LOAD;
        default: if (!pcnt_zero) pcnt <= pcnt - 16'd1;
      endcase
    end
  end

  // Collect bank and slot mask
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      mask <= '0;
      for (int i = 0; i < NUM_CH; i++) col_bank[i] <= '0;
    end else begin
      mask <= mask_nxt;
      if (col_we) col_bank[channel] <= captured_data;
    end
  end

  // Output bank, frame counter and ready flag; a commit outranks a same-cycle ack
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      frame_ready <= 1'b0;
      frame_seq   <= '0;
      for (int i = 0; i < NUM_CH; i++) out_bank[i] <= '0;
    end else if (commit) begin
      frame_ready <= 1'b1;
      frame_seq   <= frame_seq + 8'd1;
      for (int i = 0; i < NUM_CH; i++) out_bank[i] <= col_bank[i];
    end else if (frame_ack) begin
      frame_ready <= 1'b0;
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) err_status <= '0;
    else        err_status <= (clear_err ? 3'b000 : err_status) | err_set;
  end

  // Host read port: one-cycle latency, data held until the next read
  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_ack <= rd_req;
      if (rd_req) rd_data <= rd_ch_ok ? out_bank[rd_ch] : 16'h0000;
    end
  end

endmodule

// File: doc/adc_frame_collector.md
Name: adc_frame_collector

Overview:
- Sits directly downstream of the ADC serial-port controller in the same SCLK domain.
- Generates its periodic `sync` capture command.
- Collects the per-channel words that come back as `captured_data` with `rd_en` and `channel`, and assembles them into a complete 6-channel frame.
- Double-buffers each complete frame for the host read port and flags incomplete frames, duplicate channels and frame overruns.

Parameters:
- NUM_CH, 6, channels per frame; slots 0..NUM_CH-1.
- SYNC_PERIOD, 4096, SCLK cycles between sync pulses; must exceed worst-case frame time. Range 16..65535.

Ports:
- SCLK  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- enable  in  1  collector run enable.
- operation_mode  in  1  ADC controller in data mode (high) or programming (low).
- rd_en  in  1  one-cycle strobe: captured_data/channel valid.
- channel  in  3  slot index of the current word.
- captured_data  in  16  ADC sample.
- sync  out  1  one-cycle capture command to the ADC controller.
- frame_ready  out  1  output bank holds an unread complete frame.
- frame_ack  in  1  host pulse: frame consumed, clears frame_ready.
- frame_seq  out  8  count of committed frames, wraps 255->0.
- rd_req  in  1  host read request.
- rd_ch  in  3  slot to read.
- rd_data  out  16  read data.
- rd_ack  out  1  one-cycle read-data valid.
- err_status  out  3  sticky errors: [0] incomplete, [1] duplicate/bad channel, [2] overrun.
- clear_err  in  1  clears err_status.

Behaviour:
- Reset values: all outputs, mask, bank contents, counters = 0. State = IDLE.
- Reset is asynchronous; assertion mid-frame discards everything with no error flagged.

States:
- IDLE: sync=0, period counter=0. Go to ARM when enable && operation_mode.
- ARM:
  - sync=1 for exactly one cycle.
  - Period counter loads SYNC_PERIOD-1.
  - Collect mask clears.
  - Next state COLLECT.
- COLLECT:
  - Period counter decrements each cycle.
  - On rd_en with channel<NUM_CH: write captured_data into the collect bank slot[channel] and set mask[channel].
  - If mask[channel] is already set, overwrite the slot and set err_status[1].
  - On rd_en with channel>=NUM_CH: ignore the data and set err_status[1].
  - When the mask becomes all-ones (including the write in this cycle), go to COMMIT next cycle.
  - If the period counter reaches 0 with the mask incomplete: set err_status[0], discard the partial frame, go to ARM.
- COMMIT:
  - Copy the collect bank to the output bank in one cycle.
  - frame_seq increments.
  - frame_ready=1 from the next cycle.
  - If frame_ready is already 1 and frame_ack is not asserted this cycle, set err_status[2]. The new frame overwrites the old one.
  - Go to WAIT.
- WAIT:
  - Period counter keeps decrementing.
  - rd_en words are ignored and set err_status[1].
  - At 0, go to ARM.
- Sync spacing: the sync-to-sync interval is exactly SYNC_PERIOD+1 cycles in steady state, including the ARM cycle.
- Disable:
  - enable or operation_mode low in any state returns to IDLE next cycle.
  - A partial frame is discarded with no error.
  - The output bank, frame_ready and frame_seq are retained.

Host side:
- frame_ack clears frame_ready next cycle. A commit in the same cycle wins: frame_ready stays 1 and no overrun is flagged.
- Read latency:
  - rd_req in cycle N gives rd_ack=1 and rd_data=output bank[rd_ch] in cycle N+1.
  - rd_data holds until the next read.
  - rd_ch>=NUM_CH returns 0 with rd_ack=1.
  - A read in the COMMIT cycle returns the pre-commit value.
  - Back-to-back rd_req is allowed, one result per cycle.
- Errors:
  - clear_err clears err_status next cycle.
  - An error event in the same cycle as clear_err wins (bit set).

Test Plan:
- Sync period: enable=1, operation_mode=1, SYNC_PERIOD=64, no data -> sync pulses exactly 65 cycles apart. err_status[0]=1 after the first expiry.
- Full frame: after sync, 6 rd_en words ch0..5 = 16'h1000..16'h1005 -> frame_ready=1 one cycle after COMMIT, frame_seq=1. Reads of rd_ch 0..5 return 1000..1005 one cycle after each rd_req.
- Duplicate channel: ch0,ch1,ch1(16'hBEEF),ch2..5 -> frame commits with slot1=BEEF and err_status=3'b010. Then clear_err -> 000.
- Overrun: two complete frames without frame_ack -> err_status[2]=1, output bank holds the second frame, frame_seq=2. Repeat with frame_ack in the second COMMIT cycle -> no overrun.
- Incomplete: only ch0..4 before expiry -> err_status[0]=1, frame_ready unchanged, frame_seq unchanged, new sync issued.
- Mid-operation: deassert operation_mode after 3 words -> IDLE with no sync, error or commit. Async rst_l pulse mid-COLLECT -> all outputs 0 immediately.
